// File: rtl/wdt_ctrl.sv
// wdt_ctrl: bus-mapped control front end for an external watchdog timer
module wdt_ctrl #(
    parameter int KICK_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        WDEN,
    output logic        WDLIVE,
    output logic [31:0] WTOCNT,
    input  logic        WTO,
    output logic        irq
);
    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_RESP   = 1'b1;
    localparam logic [31:0] KICK_KEY = 32'h5A5A_0001;
    localparam logic [7:0]  HOLD     = 8'(KICK_HOLD);

    logic [0:0]  r_state;
    logic        r_en, r_ie, r_to, r_s1, r_s2, r_s2d, r_err;
    logic [7:0]  r_kick;
    logic [31:0] r_tocnt, r_rdata;
    logic        w_acc, w_ok, w_wr, w_rise, w_kick_bad;
    logic        w_ctrl_wr, w_kick_ok, w_toc_wr, w_stat_wr, w_err;
    logic [1:0]  w_sel;
    logic [31:0] w_rdata;

    assign w_acc      = req_valid && r_state == S_IDLE;
    assign w_ok       = req_addr[1:0] == 2'b00;
    assign w_sel      = req_addr[3:2];
    assign w_wr       = w_acc && w_ok && req_write;
    assign w_ctrl_wr  = w_wr && w_sel == 2'd0;
    assign w_kick_ok  = w_wr && w_sel == 2'd1 && req_wdata == KICK_KEY;
    assign w_toc_wr   = w_wr && w_sel == 2'd2 && !r_en;
    assign w_stat_wr  = w_wr && w_sel == 2'd3;
    assign w_kick_bad = req_write && w_sel == 2'd1 && req_wdata != KICK_KEY;
    assign w_err      = !w_ok || w_kick_bad || (req_write && w_sel == 2'd2 && r_en);
    assign w_rise     = r_s2 && !r_s2d;
    assign w_rdata    = (!w_ok || req_write) ? 32'd0 :
                        w_sel == 2'd0 ? {30'd0, r_ie, r_en} :
                        w_sel == 2'd2 ? r_tocnt :
                        w_sel == 2'd3 ? {29'd0, WDLIVE, r_s2, r_to} : 32'd0;

    assign req_ready = r_state == S_IDLE;
    assign rsp_valid = r_state == S_RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign WDEN      = r_en;
    assign WDLIVE    = r_kick != 8'd0;
    assign WTOCNT    = r_tocnt;
    assign irq       = r_to && r_ie;

    // handshake FSM; response captured at acceptance and held through RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            r_state <= S_RESP;
            r_rdata <= w_rdata;
            r_err   <= w_err;
        end else if (r_state == S_RESP && rsp_ready) begin
            r_state <= S_IDLE;
        end
    end

    // CTRL bits and timeout count; count is frozen while the watchdog runs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_tocnt <= 32'hFFFF_FFFF;
        end else begin
            if (w_ctrl_wr) begin
                r_en <= req_wdata[0];
                r_ie <= req_wdata[1];
            end
            if (w_toc_wr) r_tocnt <= req_wdata;
        end
    end

    // kick stretcher: a valid kick (re)loads the hold count, WDLIVE while nonzero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_kick <= '0;
        else if (w_kick_ok) r_kick <= HOLD;
        else if (r_kick != 8'd0) r_kick <= r_kick - 8'd1;
    end

    // WTO synchronizer and sticky timeout flag; a new edge wins over a clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_s2d <= 1'b0;
            r_to  <= 1'b0;
        end else begin
            r_s1  <= WTO;
            r_s2  <= r_s1;
            r_s2d <= r_s2;
            r_to  <= w_rise || (r_to && !(w_stat_wr && req_wdata[0]));
        end
    end
endmodule

// File: tb/tb_wdt_ctrl.sv
// tb_wdt_ctrl: table-driven and sequence checks of wdt_ctrl with a response scoreboard
module tb_wdt_ctrl;
    localparam logic [31:0] KEY = 32'h5A5A_0001;

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] d;
        logic [31:0] er;
        logic        ee;
        logic [31:0] etocnt;
        logic        eden;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk, rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
    logic        WDEN, WDLIVE, WTO, irq;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata, rsp_rdata, WTOCNT;

    int   tests = 0;
    int   fails = 0;
    int   run = 0;
    int   last_run = 0;
    rsp_t q[$];
    vec_t v[19];

    wdt_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .WDEN(WDEN), .WDLIVE(WDLIVE), .WTOCNT(WTOCNT),
        .WTO(WTO), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp unexpected: got rdata %0h want none", rsp_rdata);
            end else begin
                rsp_t e;
                e = q.pop_front();
                chk("rsp rdata", rsp_rdata, e.rdata);
                chk("rsp err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) run = 0;
        else if (WDLIVE) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    task automatic do_req(input logic w, input logic [3:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic ee);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        q.push_back('{er, ee});
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL accept timeout: got req_ready 0 want 1");
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            tests++;
            fails++;
            $display("FAIL response timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        v[0]  = '{1'b0, 4'h0, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
        v[1]  = '{1'b0, 4'h8, 32'h0,         32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
        v[2]  = '{1'b0, 4'hC, 32'h0,         32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0};
        v[3]  = '{1'b1, 4'h8, 32'd100,       32'h0,         1'b0, 32'd100,       1'b0};
        v[4]  = '{1'b1, 4'h0, 32'h1,         32'h0,         1'b0, 32'd100,       1'b1};
        v[5]  = '{1'b0, 4'h8, 32'h0,         32'd100,       1'b0, 32'd100,       1'b1};
        v[6]  = '{1'b0, 4'h0, 32'h0,         32'h1,         1'b0, 32'd100,       1'b1};
        v[7]  = '{1'b1, 4'h8, 32'd5,         32'h0,         1'b1, 32'd100,       1'b1};
        v[8]  = '{1'b0, 4'h8, 32'h0,         32'd100,       1'b0, 32'd100,       1'b1};
        v[9]  = '{1'b1, 4'h4, 32'h1234,      32'h0,         1'b1, 32'd100,       1'b1};
        v[10] = '{1'b0, 4'h4, 32'h0,         32'h0,         1'b0, 32'd100,       1'b1};
        v[11] = '{1'b0, 4'h1, 32'h0,         32'h0,         1'b1, 32'd100,       1'b1};
        v[12] = '{1'b1, 4'h2, 32'h0,         32'h0,         1'b1, 32'd100,       1'b1};
        v[13] = '{1'b0, 4'h0, 32'h0,         32'h1,         1'b0, 32'd100,       1'b1};
        v[14] = '{1'b1, 4'h0, 32'hFFFF_FFF3, 32'h0,         1'b0, 32'd100,       1'b1};
        v[15] = '{1'b0, 4'h0, 32'h0,         32'h3,         1'b0, 32'd100,       1'b1};
        v[16] = '{1'b1, 4'h0, 32'h0,         32'h0,         1'b0, 32'd100,       1'b0};
        v[17] = '{1'b1, 4'h8, 32'h55,        32'h0,         1'b0, 32'h55,        1'b0};
        v[18] = '{1'b0, 4'h8, 32'h0,         32'h55,        1'b0, 32'h55,        1'b0};

        rst = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr = 4'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        WTO = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset WDEN", {31'd0, WDEN}, 32'd0);
        chk("reset WDLIVE", {31'd0, WDLIVE}, 32'd0);
        chk("reset WTOCNT", WTOCNT, 32'hFFFF_FFFF);
        chk("reset irq", {31'd0, irq}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 19; i++) begin
            do_req(v[i].w, v[i].a, v[i].d, v[i].er, v[i].ee);
            chk($sformatf("vec%0d WTOCNT", i), WTOCNT, v[i].etocnt);
            chk($sformatf("vec%0d WDEN", i), {31'd0, WDEN}, {31'd0, v[i].eden});
            chk($sformatf("vec%0d WDLIVE", i), {31'd0, WDLIVE}, 32'd0);
        end

        do_req(1'b1, 4'h4, KEY, 32'h0, 1'b0);
        do_req(1'b0, 4'hC, 32'h0, 32'h4, 1'b0);
        repeat (20) @(negedge clk);
        chk("single kick WDLIVE cycles", last_run, 32'd8);

        @(negedge clk);
        chk("kick2 ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 4'h4;
        req_wdata = KEY;
        q.push_back('{32'h0, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b1;
        q.push_back('{32'h0, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk("double kick WDLIVE cycles", last_run, 32'd12);
        chk("double kick queue drained", q.size(), 32'd0);

        do_req(1'b1, 4'h0, 32'h2, 32'h0, 1'b0);
        @(negedge clk);
        WTO = 1'b1;
        @(negedge clk);
        chk("wto cycle1 irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("wto cycle2 irq", {31'd0, irq}, 32'd0);
        WTO = 1'b0;
        @(negedge clk);
        chk("wto cycle3 irq", {31'd0, irq}, 32'd1);
        do_req(1'b0, 4'hC, 32'h0, 32'h1, 1'b0);
        do_req(1'b1, 4'h0, 32'h2, 32'h0, 1'b0);
        chk("EN=0 keeps TO irq", {31'd0, irq}, 32'd1);
        do_req(1'b1, 4'hC, 32'h1, 32'h0, 1'b0);
        chk("clear TO irq", {31'd0, irq}, 32'd0);
        do_req(1'b0, 4'hC, 32'h0, 32'h0, 1'b0);

        do_req(1'b1, 4'h0, 32'h3, 32'h0, 1'b0);
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("stall ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 4'h8;
        q.push_back('{32'h55, 1'b0});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("stall%0d rsp_rdata", i), rsp_rdata, 32'h55);
            chk($sformatf("stall%0d req_ready", i), {31'd0, req_ready}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp_rdata", rsp_rdata, 32'h0);
        chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst WDEN", {31'd0, WDEN}, 32'd0);
        chk("rst WDLIVE", {31'd0, WDLIVE}, 32'd0);
        chk("rst WTOCNT", WTOCNT, 32'hFFFF_FFFF);
        chk("rst irq", {31'd0, irq}, 32'd0);
        q.delete();
        @(negedge clk);
        rst = 1'b1;
        rsp_ready = 1'b1;
        do_req(1'b0, 4'h0, 32'h0, 32'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
